// File: rtl/ksa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ksa_pkg                                                       |
// | Purpose  : Shared constants and the propagate/generate pair type for the |
// |            Kogge-Stone subtractor.                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ksa_pkg;

    localparam int KSA_MAX_N = 64;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

endpackage
`default_nettype wire

// File: rtl/ksa_prefix_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ksa_prefix_cell                                               |
// | Purpose  : Black-cell prefix operator merging a high and a low group.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ksa_prefix_cell
    import ksa_pkg::*;
(
    input  pg_t i_hi,
    input  pg_t i_lo,
    output pg_t o_grp
);

    assign o_grp = '{p: i_hi.p & i_lo.p, g: i_hi.g | (i_hi.p & i_lo.g)};

endmodule
`default_nettype wire

// File: rtl/ksa_sub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ksa_sub_pipe                                                  |
// | Purpose  : Three-stage valid/ready pipelined subtractor built on a       |
// |            Kogge-Stone prefix carry network.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ksa_sub_pipe
    import ksa_pkg::*;
#(
    parameter int N      = 8,
    parameter int LEVELS = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         ovf
);

    if (N < 4 || N > KSA_MAX_N || (N & (N - 1)) != 0) begin : g_n_check
        $error("ksa_sub_pipe: N must be a power of two between 4 and %0d", KSA_MAX_N);
    end

    // Stage registers
    logic         r_s1_valid, r_s2_valid, r_s3_valid;
    logic [N-1:0] r_s1_p, r_s1_g;
    logic         r_s1_c0, r_s1_a_msb;
    logic [N-1:0] r_s2_p, r_s2_gg;
    logic         r_s2_c0, r_s2_a_msb;
    logic [N-1:0] r_s3_diff;
    logic         r_s3_bo, r_s3_ovf;

    // Handshake: a stage may load when it is empty or its content moves on
    logic w_s1_ready, w_s2_ready, w_s3_ready, w_accept;

    assign w_s3_ready = !r_s3_valid || out_ready;
    assign w_s2_ready = !r_s2_valid || w_s3_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = !rst && w_s1_ready;
    assign w_accept   = in_valid && in_ready;

    // Subtraction as a + ~b + ~borrow_in; the carry-in is folded into bit 0's generate
    logic [N-1:0] w_g0;
    pg_t  [N-1:0] w_pg [0:LEVELS];
    logic [N-1:0] w_gg;

    assign w_g0 = r_s1_g | {{(N-1){1'b0}}, r_s1_p[0] & r_s1_c0};

    for (genvar i = 0; i < N; i++) begin : g_lvl0
        assign w_pg[0][i] = '{p: r_s1_p[i], g: w_g0[i]};
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        localparam int c_dist = 1 << (l - 1);
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= c_dist) begin : g_cell
                ksa_prefix_cell u_cell (
                    .i_hi  (w_pg[l-1][i]),
                    .i_lo  (w_pg[l-1][i-c_dist]),
                    .o_grp (w_pg[l][i])
                );
            end else begin : g_pass
                assign w_pg[l][i] = w_pg[l-1][i];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_gg
        assign w_gg[i] = w_pg[LEVELS][i].g;
    end

    // Group generate of bits [i:0] is the carry into bit i+1
    logic [N-1:0] w_carry, w_diff;
    logic         w_bo, w_ovf;

    assign w_carry = {r_s2_gg[N-2:0], r_s2_c0};
    assign w_diff  = r_s2_p ^ w_carry;
    assign w_bo    = ~r_s2_gg[N-1];
    // Operand signs differ exactly when the MSB propagate a ^ ~b is zero
    assign w_ovf   = ~r_s2_p[N-1] & (w_diff[N-1] ^ r_s2_a_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_c0    <= 1'b0;
            r_s1_a_msb <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_p     <= a ^ ~b;
                r_s1_g     <= a & ~b;
                r_s1_c0    <= ~borrow_in;
                r_s1_a_msb <= a[N-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_gg    <= '0;
            r_s2_c0    <= 1'b0;
            r_s2_a_msb <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_p     <= r_s1_p;
                r_s2_gg    <= w_gg;
                r_s2_c0    <= r_s1_c0;
                r_s2_a_msb <= r_s1_a_msb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3_diff  <= '0;
            r_s3_bo    <= 1'b0;
            r_s3_ovf   <= 1'b0;
        end else if (w_s3_ready) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_diff <= w_diff;
                r_s3_bo   <= w_bo;
                r_s3_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid  = r_s3_valid;
    assign diff       = r_s3_diff;
    assign borrow_out = r_s3_bo;
    assign ovf        = r_s3_ovf;

endmodule
`default_nettype wire
